wsp_driver: RTL and testbench

WSP_DRIVER -- requirements
Module: wsp_driver

---
 rtl/wsp_driver_pkg.sv | 34 +++
 rtl/wsp_driver_shifter.sv | 63 ++++++
 rtl/wsp_driver.sv | 151 +++++++++++++++
 tb/tb_wsp_driver.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/wsp_driver_pkg.sv
// Shared definitions for the wrapper serial port driver: controller states,
// default scan width and the 3-bit WIR instruction codes.
package wsp_driver_pkg;

    localparam int DR_MAX_DEFAULT = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURE = 3'd1,
        SHIFT   = 3'd2,
        UPDATE  = 3'd3,
        DONE    = 3'd4
    } wsp_state_e;

    // All-zero instruction selects the one-bit bypass register.
    localparam logic [2:0] WIR_BYPASS  = 3'b000;
    localparam logic [2:0] WIR_EXTEST  = 3'b001;
    localparam logic [2:0] WIR_INTEST  = 3'b010;
    localparam logic [2:0] WIR_SAMPLE  = 3'b011;
    localparam logic [2:0] WIR_PRELOAD = 3'b100;

    // Limit a requested shift length to the widest scannable register.
    function automatic logic [31:0] clamp_len(input logic [5:0]  len,
                                              input logic [31:0] max_len);
        logic [31:0] len_ext;
        len_ext = {26'd0, len};
        if (len_ext > max_len) begin
            clamp_len = max_len;
        end else begin
            clamp_len = len_ext;
        end
    endfunction

endpackage

// File: rtl/wsp_driver_shifter.sv
// wsp_shifter: parallel-load, LSB-out shift register; with WSP_READBACK_EN it
// also gathers serial return bits by position into cap_data.
module wsp_shifter #(
    parameter int W  = 32,
    parameter int IW = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [W-1:0]  load_data,
    input  logic          shift_en,
    output logic          sout,
    input  logic          cap_clr,
    input  logic          cap_en,
    input  logic [IW-1:0] cap_idx,
    input  logic          cap_in,
    output logic [W-1:0]  cap_data
);

    logic [W-1:0] sr_r;

    // Outgoing data register: load on request, shift toward bit 0 while scanning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_r <= '0;
        end else if (load) begin
            sr_r <= load_data;
        end else if (shift_en) begin
            sr_r <= {1'b0, sr_r[W-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign sout = sr_r[0];

`ifdef WSP_READBACK_EN
    logic [W-1:0] cap_r;
    logic [W-1:0] cap_bit_s;

    assign cap_bit_s = {{(W-1){1'b0}}, cap_in} << cap_idx;

    // Readback register: cleared per operation, then written one position per shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r <= '0;
        end else if (cap_clr) begin
            cap_r <= '0;
        end else if (cap_en) begin
            cap_r <= cap_r | cap_bit_s;
        end else begin
            cap_r <= cap_r;
        end
    end

    assign cap_data = cap_r;
`else
    logic unused_cap_s;
    assign unused_cap_s = ^{cap_clr, cap_en, cap_idx, cap_in};
    assign cap_data     = '0;
`endif

endmodule

// File: rtl/wsp_driver.sv
// Wrapper serial port driver: runs one CAPTURE/SHIFT/UPDATE scan of the WIR or
// selected WDR per start request. Define WSP_READBACK_EN to collect WSO into data_out.
module wsp_driver
    import wsp_driver_pkg::*;
#(
    parameter int DR_MAX = DR_MAX_DEFAULT
) (
    input  logic              WRCK,
    input  logic              WRSTN,
    input  logic              start,
    input  logic              is_ir,
    input  logic [5:0]        shift_len,
    input  logic [DR_MAX-1:0] data_in,
    input  logic              WSO,
    output logic              SelectWIR,
    output logic              CaptureWR,
    output logic              ShiftWR,
    output logic              UpdateWR,
    output logic              WSI,
    output logic              busy,
    output logic              done,
    output logic [DR_MAX-1:0] data_out
);

    localparam int          CW       = $clog2(DR_MAX + 1);
    localparam logic [31:0] DR_MAX_U = 32'(DR_MAX);

    wsp_state_e    state_r;
    wsp_state_e    next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] eff_len_r;
    logic [CW-1:0] eff_len_s;
    logic [CW-1:0] shift_idx_s;
    logic          ir_r;
    logic          start_op_s;
    logic          shift_next_s;
    logic          sel_active_s;
    logic          sel_val_s;
    logic          sr_bit_s;

    assign eff_len_s    = CW'(clamp_len(shift_len, DR_MAX_U));
    assign start_op_s   = (state_r == IDLE) && start;
    assign shift_next_s = (next_s == SHIFT);
    assign shift_idx_s  = eff_len_r - cnt_r;

    // Next-state decode; the counter holds the shifts still to go, so 1 means last.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = CAPTURE;
                end else begin
                    next_s = IDLE;
                end
            end
            CAPTURE: begin
                if (cnt_r == {CW{1'b0}}) begin
                    next_s = UPDATE;
                end else begin
                    next_s = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_r == CW'(1)) begin
                    next_s = UPDATE;
                end else begin
                    next_s = SHIFT;
                end
            end
            UPDATE:  next_s = DONE;
            DONE:    next_s = IDLE;
            default: next_s = IDLE;
        endcase
    end

    // Select value for the upcoming cycle: fresh request value on entry, latched after.
    always_comb begin
        sel_active_s = 1'b0;
        sel_val_s    = ir_r;
        if (start_op_s) begin
            sel_val_s = is_ir;
        end else begin
            sel_val_s = ir_r;
        end
        case (next_s)
            CAPTURE, SHIFT, UPDATE: sel_active_s = 1'b1;
            default:                sel_active_s = 1'b0;
        endcase
    end

    // State register, shift counter and per-operation request latches.
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            eff_len_r <= {CW{1'b0}};
            ir_r      <= 1'b0;
        end else begin
            state_r <= next_s;
            if (start_op_s) begin
                cnt_r     <= eff_len_s;
                eff_len_r <= eff_len_s;
                ir_r      <= is_ir;
            end else if (state_r == SHIFT) begin
                cnt_r <= cnt_r - CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Port outputs are registered from the next state so they line up with it.
    always_ff @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            SelectWIR <= 1'b0;
            CaptureWR <= 1'b0;
            ShiftWR   <= 1'b0;
            UpdateWR  <= 1'b0;
            WSI       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            SelectWIR <= sel_active_s & sel_val_s;
            CaptureWR <= (next_s == CAPTURE);
            ShiftWR   <= shift_next_s;
            UpdateWR  <= (next_s == UPDATE);
            WSI       <= shift_next_s & sr_bit_s;
            busy      <= (next_s != IDLE);
            done      <= (next_s == DONE);
        end
    end

    wsp_shifter #(
        .W  (DR_MAX),
        .IW (CW)
    ) u_shifter (
        .clk       (WRCK),
        .rst_n     (WRSTN),
        .load      (start_op_s),
        .load_data (data_in),
        .shift_en  (shift_next_s),
        .sout      (sr_bit_s),
        .cap_clr   (start_op_s),
        .cap_en    (state_r == SHIFT),
        .cap_idx   (shift_idx_s),
        .cap_in    (WSO),
        .cap_data  (data_out)
    );

endmodule

// File: tb/tb_wsp_driver.sv
// Self-checking bench for wsp_driver: cycle-timeline model plus directed scans.
`timescale 1ns/1ps
module tb_wsp_driver;

    localparam int DR_MAX = 32;

    logic              WRCK      = 1'b0;
    logic              WRSTN     = 1'b0;
    logic              start     = 1'b0;
    logic              is_ir     = 1'b0;
    logic [5:0]        shift_len = 6'd0;
    logic [DR_MAX-1:0] data_in   = '0;
    logic              WSO       = 1'b0;
    logic              SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done;
    logic [DR_MAX-1:0] data_out;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    wsp_driver #(.DR_MAX(DR_MAX)) dut (
        .WRCK      (WRCK),
        .WRSTN     (WRSTN),
        .start     (start),
        .is_ir     (is_ir),
        .shift_len (shift_len),
        .data_in   (data_in),
        .WSO       (WSO),
        .SelectWIR (SelectWIR),
        .CaptureWR (CaptureWR),
        .ShiftWR   (ShiftWR),
        .UpdateWR  (UpdateWR),
        .WSI       (WSI),
        .busy      (busy),
        .done      (done),
        .data_out  (data_out)
    );

    always #5 WRCK = ~WRCK;

    // wrapper loopback: WSO is WSI delayed by one WRCK
    always @(posedge WRCK) WSO <= WSI;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: m_t = cycles since start was sampled (0 = idle). Cycle 1 capture,
    // cycles 2..L+1 shift bit t-2, L+2 update, L+3 done.
    int                m_t   = 0;
    int                m_len = 0;
    bit                m_ir  = 1'b0;
    logic [DR_MAX-1:0] m_data = '0;
    logic [DR_MAX-1:0] m_rb   = '0;

    always @(posedge WRCK or negedge WRSTN) begin
        if (!WRSTN) begin
            m_t  = 0;
            m_rb = '0;
        end else if (m_t == 0) begin
            if (start) begin
                m_len  = (int'(shift_len) > DR_MAX) ? DR_MAX : int'(shift_len);
                m_ir   = is_ir;
                m_data = data_in;
                m_rb   = '0;
                m_t    = 1;
            end
        end else begin
            if (m_t >= 2 && m_t <= m_len + 1) m_rb[m_t-2] = WSO;
            if (m_t == m_len + 3) m_t = 0;
            else m_t = m_t + 1;
        end
    end

    logic [6:0]        exp_v;
    logic [6:0]        act_v;
    logic [DR_MAX-1:0] exp_do;
    bit                e_sh;

    always @(negedge WRCK) begin
        if (chk_en) begin
            e_sh  = (m_t >= 2) && (m_t <= m_len + 1);
            exp_v = {(m_t >= 1 && m_t <= m_len + 2) ? m_ir : 1'b0,
                     m_t == 1,
                     e_sh,
                     m_t == m_len + 2,
                     e_sh ? m_data[m_t-2] : 1'b0,
                     m_t != 0,
                     m_t == m_len + 3};
            act_v = {SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done};
`ifdef WSP_READBACK_EN
            exp_do = m_rb;
`else
            exp_do = '0;
`endif
            chk("model_outputs", 64'(act_v), 64'(exp_v));
            chk("model_data_out", 64'(data_out), 64'(exp_do));
        end
    end

    task automatic run_op(input bit ir, input logic [5:0] len, input logic [DR_MAX-1:0] d,
                          output int dcyc, output int nsh, output int ncap, output int nupd,
                          output bit sel_bad, output logic [63:0] seq);
        @(negedge WRCK);
        is_ir = ir; shift_len = len; data_in = d; start = 1'b1;
        dcyc = -1; nsh = 0; ncap = 0; nupd = 0; sel_bad = 1'b0; seq = '0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge WRCK);
            if (i == 1) start = 1'b0;
            if (CaptureWR) ncap++;
            if (ShiftWR) begin seq[nsh] = WSI; nsh++; end
            if (UpdateWR) nupd++;
            if ((CaptureWR || ShiftWR || UpdateWR) && SelectWIR !== ir) sel_bad = 1'b1;
            if (done) begin dcyc = i; break; end
        end
        if (dcyc < 0) chk("op_timeout", 64'd0, 64'd1);
    endtask

    int          dc, ns, nc, nu, gap;
    bit          sb, seen;
    logic [63:0] sq;
    logic [63:0] rb_exp;

    initial begin
        repeat (2) @(negedge WRCK);
        chk("reset_state", 64'({SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done, data_out}), 64'd0);
        WRSTN  = 1'b1;
        chk_en = 1'b1;
        @(negedge WRCK);

        // WIR load of 3'b101
        run_op(1'b1, 6'd3, 32'h5, dc, ns, nc, nu, sb, sq);
        chk("wir_done_cycle", 64'(dc), 64'd6);
        chk("wir_shifts", 64'(ns), 64'd3);
        chk("wir_wsi_seq", 64'(sq[2:0]), 64'h5);
        chk("wir_capture_cnt", 64'(nc), 64'd1);
        chk("wir_update_cnt", 64'(nu), 64'd1);
        chk("wir_select", 64'(sb), 64'd0);

        // WDR 0xA5 with loopback
        run_op(1'b0, 6'd8, 32'hA5, dc, ns, nc, nu, sb, sq);
        chk("wdr_shifts", 64'(ns), 64'd8);
        chk("wdr_done_cycle", 64'(dc), 64'd11);
        chk("wdr_wsi_seq", 64'(sq[7:0]), 64'hA5);
        chk("wdr_select", 64'(sb), 64'd0);
        @(negedge WRCK);
`ifdef WSP_READBACK_EN
        rb_exp = 64'h4A;
`else
        rb_exp = 64'h0;
`endif
        chk("wdr_readback", 64'(data_out), rb_exp);

        // zero length
        run_op(1'b1, 6'd0, 32'hFFFF_FFFF, dc, ns, nc, nu, sb, sq);
        chk("zero_done_cycle", 64'(dc), 64'd3);
        chk("zero_shifts", 64'(ns), 64'd0);
        chk("zero_capture_cnt", 64'(nc), 64'd1);
        chk("zero_update_cnt", 64'(nu), 64'd1);

        // clamp 40 -> 32
        run_op(1'b0, 6'd40, 32'hDEAD_BEEF, dc, ns, nc, nu, sb, sq);
        chk("clamp_shifts", 64'(ns), 64'd32);
        chk("clamp_done_cycle", 64'(dc), 64'd35);
        chk("clamp_wsi_seq", 64'(sq[31:0]), 64'hDEAD_BEEF);

        // back-to-back with start held high
        @(negedge WRCK);
        is_ir = 1'b0; shift_len = 6'd2; data_in = 32'h2; start = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge WRCK);
            if (done) seen = 1'b1;
        end
        chk("b2b_first_done", 64'(seen), 64'd1);
        gap = -1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge WRCK);
            if (i == 1) chk("b2b_idle_gap", 64'({busy, CaptureWR}), 64'd0);
            if (CaptureWR) begin gap = i; break; end
        end
        chk("b2b_capture_gap", 64'(gap), 64'd2);
        start = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge WRCK);
            if (done) seen = 1'b1;
        end
        chk("b2b_second_done", 64'(seen), 64'd1);
        repeat (2) @(negedge WRCK);

        // reset abort on shift cycle 2 of an 8-bit scan
        is_ir = 1'b1; shift_len = 6'd8; data_in = 32'hFF; start = 1'b1;
        ns = 0;
        for (int i = 0; i < 20 && ns < 3; i++) begin
            @(negedge WRCK);
            start = 1'b0;
            if (ShiftWR) ns++;
        end
        chk("abort_reached_shift", 64'(ns), 64'd3);
        #2 WRSTN = 1'b0;
        #1 chk("abort_outputs", 64'({SelectWIR, CaptureWR, ShiftWR, UpdateWR, WSI, busy, done, data_out}), 64'd0);
        @(negedge WRCK);
        #1 WRSTN = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge WRCK);
            if (UpdateWR || busy) seen = 1'b1;
        end
        chk("abort_no_update", 64'(seen), 64'd0);

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
